fast_div: RTL and testbench

Iterative restoring divider: the inverse companion to the table-lookup 4x4 multiplier in the arithmetic examples. It accepts an unsigned dividend/divisor pair over a valid/ready handshake and computes one quotient bit per cycle. It returns quotient, remainder and a divide-by-zero flag over a second valid/ready handshake. It sits between an operand producer and a result consumer, one operation in flight.

---
 rtl/fast_div_pkg.sv | 19 +
 rtl/fast_div_if.sv | 25 ++
 rtl/fast_div_step.sv | 19 +
 rtl/fast_div.sv | 98 +++++++++
 tb/tb_fast_div.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/fast_div_pkg.sv
// Shared types and width helpers for the iterative restoring divider.
package fast_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_DIVIDEND_WIDTH = 8;
  localparam int DEF_DIVISOR_WIDTH  = 4;
  localparam int DEF_CNT_WIDTH      = $clog2(DEF_DIVIDEND_WIDTH);

  // Iteration counter width; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fast_div_if.sv
// Operand and result handshakes of fast_div grouped as one bundle.
interface fast_div_if #(
  parameter int DIVIDEND_WIDTH = 8,
  parameter int DIVISOR_WIDTH  = 4
);
  logic                      io_in_valid;
  logic                      io_in_ready;
  logic [DIVIDEND_WIDTH-1:0] io_in_dividend;
  logic [DIVISOR_WIDTH-1:0]  io_in_divisor;
  logic                      io_out_valid;
  logic                      io_out_ready;
  logic [DIVIDEND_WIDTH-1:0] io_out_quot;
  logic [DIVISOR_WIDTH-1:0]  io_out_rem;
  logic                      io_out_divzero;

  modport master (
    output io_in_valid, io_in_dividend, io_in_divisor, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_quot, io_out_rem, io_out_divzero
  );

  modport slave (
    input  io_in_valid, io_in_dividend, io_in_divisor, io_out_ready,
    output io_in_ready, io_out_valid, io_out_quot, io_out_rem, io_out_divzero
  );
endinterface

// File: rtl/fast_div_step.sv
// One combinational restoring-division step: shift in a bit, trial-subtract.
module div_step #(
  parameter int DIVISOR_WIDTH = 4
) (
  input  logic [DIVISOR_WIDTH:0]   prem_i,
  input  logic                     bit_i,
  input  logic [DIVISOR_WIDTH-1:0] divisor_i,
  output logic [DIVISOR_WIDTH:0]   prem_o,
  output logic                     qbit_o
);
  logic [DIVISOR_WIDTH:0] shifted;

  always_comb begin
    shifted = {prem_i[DIVISOR_WIDTH-1:0], bit_i};
    // A set top bit means the shifted value already exceeds any divisor.
    qbit_o  = prem_i[DIVISOR_WIDTH] || (shifted >= {1'b0, divisor_i});
    prem_o  = qbit_o ? (shifted - {1'b0, divisor_i}) : shifted;
  end
endmodule

// File: rtl/fast_div.sv
// Iterative unsigned divider: one quotient bit per clock, single op in flight.
module fast_div
  import fast_div_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,
  parameter int DIVISOR_WIDTH  = DEF_DIVISOR_WIDTH
) (
  input  logic     clk,
  input  logic     reset,
  fast_div_if.slave bus
);
  localparam int                CW   = cnt_width(DIVIDEND_WIDTH);
  localparam logic [CW-1:0]     LAST = CW'(DIVIDEND_WIDTH - 1);

  state_e                    state_q, state_d;
  logic [DIVIDEND_WIDTH-1:0] quot_q, quot_d;
  logic [DIVISOR_WIDTH:0]    prem_q, prem_d;
  logic [DIVISOR_WIDTH-1:0]  divisor_q, divisor_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      divzero_q, divzero_d;
  logic                      valid_q, valid_d;

  logic [DIVISOR_WIDTH:0]    prem_step;
  logic                      qbit_step;

  div_step #(.DIVISOR_WIDTH(DIVISOR_WIDTH)) u_step (
    .prem_i   (prem_q),
    .bit_i    (quot_q[DIVIDEND_WIDTH-1]),
    .divisor_i(divisor_q),
    .prem_o   (prem_step),
    .qbit_o   (qbit_step)
  );

  always_comb begin
    state_d   = state_q;
    quot_d    = quot_q;
    prem_d    = prem_q;
    divisor_d = divisor_q;
    cnt_d     = cnt_q;
    divzero_d = divzero_q;
    case (state_q)
      IDLE: begin
        if (bus.io_in_valid) begin
          divisor_d = bus.io_in_divisor;
          prem_d    = '0;
          cnt_d     = '0;
          divzero_d = (bus.io_in_divisor == '0);
          if (bus.io_in_divisor == '0) begin
            quot_d  = '1;
            state_d = DONE;
          end else begin
            quot_d  = bus.io_in_dividend;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        // Quotient register doubles as the dividend shifter.
        prem_d = prem_step;
        quot_d = {quot_q[DIVIDEND_WIDTH-2:0], qbit_step};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (bus.io_out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      quot_q    <= '0;
      prem_q    <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      divzero_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      quot_q    <= quot_d;
      prem_q    <= prem_d;
      divisor_q <= divisor_d;
      cnt_q     <= cnt_d;
      divzero_q <= divzero_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.io_in_ready    = (state_q == IDLE);
  assign bus.io_out_valid   = valid_q;
  assign bus.io_out_quot    = quot_q;
  assign bus.io_out_rem     = prem_q[DIVISOR_WIDTH-1:0];
  assign bus.io_out_divzero = divzero_q;

endmodule

// File: tb/tb_fast_div.sv
// Randomized and directed bench for fast_div against a plain-arithmetic model.
module tb_fast_div;
  localparam int DW = 8;
  localparam int VW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fast_div_if #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW)) bus();

  fast_div #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic void ref_div(input int a, input int b,
                                  output int q, output int r, output int dz);
    if (b == 0) begin
      q = (1 << DW) - 1; r = 0; dz = 1;
    end else begin
      q = a / b; r = a % b; dz = 0;
    end
  endfunction

  // Entered at a negedge; returns at the negedge after the accept edge.
  task automatic start_op(input int a, input int b);
    int g;
    bus.io_in_dividend = a[DW-1:0];
    bus.io_in_divisor  = b[VW-1:0];
    bus.io_in_valid    = 1'b1;
    g = 0;
    while (!bus.io_in_ready && g < 30) begin
      @(negedge clk);
      g++;
    end
    if (!bus.io_in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    bus.io_in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.io_out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.io_out_valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic run_op(input string tag, input int a, input int b);
    int lat, q, r, dz;
    start_op(a, b);
    wait_valid(lat);
    ref_div(a, b, q, r, dz);
    chk({tag, "_quot"}, bus.io_out_quot, q);
    chk({tag, "_rem"}, bus.io_out_rem, r);
    chk({tag, "_divzero"}, bus.io_out_divzero, dz);
    chk({tag, "_latency"}, lat, (dz != 0) ? 0 : DW);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int lat, seen, g;
    int idx[$];
    int perm[4096];

    bus.io_in_valid    = 1'b0;
    bus.io_in_dividend = '0;
    bus.io_in_divisor  = '0;
    bus.io_out_ready   = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.io_in_ready, 1);
    chk("rst_out_valid", bus.io_out_valid, 0);
    chk("rst_quot", bus.io_out_quot, 0);
    chk("rst_rem", bus.io_out_rem, 0);
    chk("rst_divzero", bus.io_out_divzero, 0);
    reset = 1'b1;
    @(negedge clk);

    run_op("d200_7", 200, 7);
    run_op("d255_15", 255, 15);
    run_op("d5_9", 5, 9);
    run_op("d42_0", 42, 0);
    run_op("d12_5", 12, 5);

    // Backpressure: result must hold while the consumer stalls.
    bus.io_out_ready = 1'b0;
    start_op(100, 3);
    wait_valid(lat);
    chk("bp_latency", lat, DW);
    for (int i = 0; i < 5; i++) begin
      chk("bp_quot", bus.io_out_quot, 33);
      chk("bp_rem", bus.io_out_rem, 1);
      chk("bp_in_ready", bus.io_in_ready, 0);
      chk("bp_valid", bus.io_out_valid, 1);
      bus.io_in_valid    = 1'b1;
      bus.io_in_dividend = 8'd7;
      bus.io_in_divisor  = 4'd1;
      @(negedge clk);
    end
    bus.io_in_valid  = 1'b0;
    bus.io_out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_ready", bus.io_in_ready, 1);
    chk("bp_release_valid", bus.io_out_valid, 0);
    @(negedge clk);

    // Asynchronous reset partway through the iteration.
    start_op(200, 7);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("arst_in_ready", bus.io_in_ready, 1);
    chk("arst_valid", bus.io_out_valid, 0);
    chk("arst_quot", bus.io_out_quot, 0);
    chk("arst_rem", bus.io_out_rem, 0);
    chk("arst_divzero", bus.io_out_divzero, 0);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.io_out_valid) seen = 1;
    end
    chk("arst_no_result", seen, 0);
    run_op("d9_3", 9, 3);

    // Throughput with operands always offered and results always taken.
    bus.io_in_dividend = 8'd200;
    bus.io_in_divisor  = 4'd7;
    bus.io_in_valid    = 1'b1;
    for (int c = 0; c < 25; c++) begin
      if (bus.io_in_ready) idx.push_back(c);
      @(negedge clk);
    end
    bus.io_in_valid = 1'b0;
    if (idx.size() >= 2) chk("throughput_gap", idx[1] - idx[0], DW + 2);
    else chk("throughput_accepts", idx.size(), 2);
    g = 0;
    while (!bus.io_in_ready && g < 30) begin
      @(negedge clk);
      g++;
    end
    chk("drain_idle", bus.io_in_ready, 1);

    // Every operand pair, in a shuffled order.
    for (int i = 0; i < 4096; i++) perm[i] = i;
    for (int i = 4095; i > 0; i--) begin
      int j, t;
      j = $urandom_range(i, 0);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < 4096; i++) run_op("sweep", perm[i] >> 4, perm[i] & 15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
